time_display: RTL and testbench

Display driver for the microwave timer, directly downstream of the countdown block. It consumes the `min`/`sec` values and status flags, converts them to decimal digits, and time-multiplexes four 7-segment digits on the board's 8-anode display. It also produces the blink effect while paused and a dash pattern when cooking is done.

---
 rtl/time_display_if.sv | 12 +
 rtl/time_display.sv | 84 ++++++++
 tb/tb_time_display.sv | 135 +++++++++++++
 3 files changed

// File: rtl/time_display_if.sv
// time_display_if: timer values, status flags and multiplexed display lines
interface time_display_if;
    logic [6:0] min;
    logic [6:0] sec;
    logic enable;
    logic blink;
    logic done;
    logic [7:0] an;
    logic [7:0] dec_cat;
    modport master (output min, sec, enable, blink, done, input an, dec_cat);
    modport slave (input min, sec, enable, blink, done, output an, dec_cat);
endinterface

// File: rtl/time_display.sv
// time_display: BCD split of min/sec and 4-digit multiplexed 7-segment drive with blink and dash modes
module time_display #(
    parameter int REFRESH_COUNT = 100_000,
    parameter int BLINK_COUNT = 50_000_000
) (
    input logic clock,
    input logic reset,
    time_display_if.slave bus
);
    localparam int RW = $clog2(REFRESH_COUNT);
    localparam int BW = $clog2(BLINK_COUNT);
    logic [RW-1:0] ref_cnt;
    logic [BW-1:0] blink_cnt;
    logic [1:0] idx;
    logic phase;
    logic [3:0] sec_u, sec_t, min_u, min_t;
    logic en_q, blink_q, done_q;
    logic [6:0] min_c, sec_c;
    logic [3:0] digit;
    logic [7:0] seg, cat_n, an_n;
    logic ref_wrap, blink_wrap, blank;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: return 8'b0000_0011;
            4'd1: return 8'b1001_1111;
            4'd2: return 8'b0010_0101;
            4'd3: return 8'b0000_1101;
            4'd4: return 8'b1001_1001;
            4'd5: return 8'b0100_1001;
            4'd6: return 8'b0100_0001;
            4'd7: return 8'b0001_1111;
            4'd8: return 8'b0000_0001;
            4'd9: return 8'b0000_1001;
            default: return 8'hFF;
        endcase
    endfunction

    always_comb begin
        min_c = bus.min > 7'd99 ? 7'd99 : bus.min;
        sec_c = bus.sec > 7'd99 ? 7'd99 : bus.sec;
        ref_wrap = ref_cnt == RW'(REFRESH_COUNT - 1);
        blink_wrap = blink_cnt == BW'(BLINK_COUNT - 1);
        blank = !en_q || (blink_q && !phase);
        digit = idx == 2'd0 ? sec_u : idx == 2'd1 ? sec_t : idx == 2'd2 ? min_u : min_t;
        seg = seg7(digit);
        // dp on the min-units digit acts as the mm.ss separator
        cat_n = blank ? 8'hFF :
                done_q ? 8'b1111_1101 :
                (idx == 2'd3 && min_t == 4'd0) ? 8'hFF :
                idx == 2'd2 ? (seg & 8'hFE) : seg;
        an_n = blank ? 8'hFF : ~(8'd1 << idx);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ref_cnt <= '0;
            blink_cnt <= '0;
            idx <= 2'd0;
            phase <= 1'b1;
            {sec_u, sec_t, min_u, min_t} <= '0;
            // display defaults to on so the first edge out of reset already shows a digit
            en_q <= 1'b1;
            blink_q <= 1'b0;
            done_q <= 1'b0;
            bus.an <= 8'hFF;
            bus.dec_cat <= 8'hFF;
        end else begin
            ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
            if (ref_wrap) idx <= idx + 2'd1;
            blink_cnt <= (!blink_q || blink_wrap) ? '0 : blink_cnt + 1'b1;
            phase <= !blink_q ? 1'b1 : blink_wrap ? !phase : phase;
            sec_u <= 4'(sec_c % 7'd10);
            sec_t <= 4'(sec_c / 7'd10);
            min_u <= 4'(min_c % 7'd10);
            min_t <= 4'(min_c / 7'd10);
            en_q <= bus.enable;
            blink_q <= bus.blink;
            done_q <= bus.done;
            bus.an <= an_n;
            bus.dec_cat <= cat_n;
        end
    end
endmodule

// File: tb/tb_time_display.sv
// tb_time_display: directed steps with a queue of expected an/dec_cat per clock edge
module tb_time_display;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    time_display_if bus();
    time_display #(.REFRESH_COUNT(4), .BLINK_COUNT(8)) dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct { logic [7:0] an; logic [7:0] cat; string tag; } exp_t;
    exp_t q[$];
    int k;
    int checks = 0;
    int fails = 0;

    localparam logic [3:0][7:0] AN = {8'hF7, 8'hFB, 8'hFD, 8'hFE};
    localparam logic [3:0][7:0] T1 = {8'b1001_1111, 8'b0010_0100, 8'b0000_1101, 8'b1001_1001};
    localparam logic [3:0][7:0] T5 = {8'hFF, 8'b0100_1000, 8'b0000_0011, 8'b0000_0011};
    localparam logic [3:0][7:0] CL = {8'b0000_1001, 8'b0000_1000, 8'b0000_0011, 8'b0000_0011};
    localparam logic [3:0][7:0] DS = {4{8'b1111_1101}};
    localparam logic [3:0][7:0] ZR = {8'hFF, 8'b0000_0010, 8'b0000_0011, 8'b0000_0011};

    task automatic push_raw(input logic [7:0] a, input logic [7:0] c, input string tag);
        q.push_back('{an: a, cat: c, tag: tag});
    endtask

    // edge numbers count from the first edge after reset release; digit index follows the 4-cycle dwell
    task automatic plan(input int n, input logic [3:0][7:0] cats, input bit vis, input string tag);
        for (int i = 0; i < n; i++) begin
            int e = k + q.size() + 1;
            int d = ((e - 1) / 4) % 4;
            q.push_back('{an: vis ? AN[d] : 8'hFF, cat: vis ? cats[d] : 8'hFF, tag: tag});
        end
    endtask

    task automatic drain();
        while (q.size() > 0) begin
            exp_t x;
            @(posedge clock);
            #1;
            k++;
            x = q.pop_front();
            checks++;
            assert (bus.an === x.an) else begin
                fails++;
                $error("FAIL %s an edge %0d: got %h expected %h", x.tag, k, bus.an, x.an);
            end
            checks++;
            assert (bus.dec_cat === x.cat) else begin
                fails++;
                $error("FAIL %s dec_cat edge %0d: got %b expected %b", x.tag, k, bus.dec_cat, x.cat);
            end
        end
    endtask

    initial begin
        int e;
        bus.min = 7'd12;
        bus.sec = 7'd34;
        bus.enable = 1'b1;
        bus.blink = 1'b0;
        bus.done = 1'b0;
        k = 0;
        push_raw(8'hFF, 8'hFF, "reset");
        push_raw(8'hFF, 8'hFF, "reset");
        push_raw(8'hFF, 8'hFF, "reset");
        drain();
        reset = 1'b1;
        k = 0;
        push_raw(8'hFE, 8'b0000_0011, "start");
        plan(31, T1, 1'b1, "scan_12_34");
        drain();

        bus.min = 7'd5;
        bus.sec = 7'd0;
        plan(1, T1, 1'b1, "latency_old");
        plan(16, T5, 1'b1, "leading_blank");
        drain();
        bus.min = 7'd120;
        plan(1, T5, 1'b1, "latency_old2");
        plan(16, CL, 1'b1, "clamp");
        drain();

        bus.blink = 1'b1;
        plan(9, CL, 1'b1, "blink_on1");
        plan(8, CL, 1'b0, "blink_off1");
        plan(8, CL, 1'b1, "blink_on2");
        plan(4, CL, 1'b0, "blink_off2");
        drain();
        bus.blink = 1'b0;
        plan(1, CL, 1'b0, "unblink_lat");
        plan(16, CL, 1'b1, "unblink");
        drain();

        bus.done = 1'b1;
        bus.min = 7'd0;
        bus.sec = 7'd0;
        plan(1, CL, 1'b1, "done_lat");
        plan(16, DS, 1'b1, "dash");
        drain();
        bus.blink = 1'b1;
        plan(9, DS, 1'b1, "dash_blink_on");
        plan(8, DS, 1'b0, "dash_blink_off");
        drain();
        bus.blink = 1'b0;
        plan(4, DS, 1'b1, "dash_unblink");
        drain();
        bus.done = 1'b0;
        plan(1, DS, 1'b1, "undone_lat");
        plan(16, ZR, 1'b1, "zero");
        drain();

        bus.enable = 1'b0;
        plan(1, ZR, 1'b1, "disable_lat");
        plan(8, ZR, 1'b0, "disabled");
        drain();
        bus.enable = 1'b1;
        plan(1, ZR, 1'b0, "enable_lat");
        e = k + 2;
        while (((e - 1) / 4) % 4 != 2) e++;
        plan(e - k - 1, ZR, 1'b1, "pre_reset");
        drain();
        reset = 1'b0;
        push_raw(8'hFF, 8'hFF, "mid_reset");
        drain();
        reset = 1'b1;
        k = 0;
        push_raw(8'hFE, 8'b0000_0011, "restart");
        plan(15, ZR, 1'b1, "rescan");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
